serial_subtractor_4bits: RTL and testbench

- Bit-serial binary subtractor. Computes Diff = A - B - Bin one bit per clock, LSB first, using a single full-subtractor cell and a borrow flip-flop.
- It is the inverse-operation counterpart of the parallel 4-bit full adder: same operand width and carry/borrow-in/out convention, but the result is produced sequentially.
- Used in the logic-design lab flow to show a sequential datapath against the combinational adder, and as an adder cross-checker (A + B - B == A).

---
 rtl/serial_subtractor_4bits.sv | 182 ++++++++++++++++++
 tb/tb_serial_subtractor_4bits.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor_4bits.sv
// -----------------------------------------------------------------------------
// serial_subtractor_4bits
//
// Bit-serial binary subtractor: Diff = A - B - Bin, one bit per clock, LSB
// first. It uses a single full-subtractor cell and a borrow flip-flop. It is
// the sequential counterpart of the parallel 4-bit full adder.
//
// Optional feature macro: SERIAL_SUB_OVF_EN
//   When defined, adds the 'ovf' output. This is the signed two's-complement
//   overflow flag, updated together with Diff.
//
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   start  in   operation request, sampled only while idle
//   A      in   minuend, captured on the accepted start
//   B      in   subtrahend, captured on the accepted start
//   Bin    in   borrow-in, captured on the accepted start
//   busy   out  high while bits are being processed (WIDTH cycles)
//   done   out  one-cycle pulse when Diff/Bout are freshly valid
//   Diff   out  registered difference, held until the next result
//   Bout   out  registered borrow-out (unsigned underflow)
//   ovf    out  (SERIAL_SUB_OVF_EN only) signed overflow, held with Diff
// -----------------------------------------------------------------------------
module serial_subtractor_4bits #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Diff,
  output logic             Bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LastBit = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] aReg_q, aReg_d;
  logic [WIDTH-1:0] bReg_q, bReg_d;
  logic [WIDTH-1:0] resReg_q, resReg_d;
  logic             borrow_q, borrow_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             done_q, done_d;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovfBit_q, ovfBit_d;
  logic             ovf_q, ovf_d;
`endif

  // Full-subtractor cell acting on the current LSBs of the operand registers.
  logic aBit, bBit, dBit, brNext;

  always_comb begin
    aBit   = aReg_q[0];
    bBit   = bReg_q[0];
    dBit   = aBit ^ bBit ^ borrow_q;
    brNext = (~aBit & bBit) | (~(aBit ^ bBit) & borrow_q);
  end

  // Next-state and datapath logic. The outputs are loaded only in DONE, so
  // they stay stable while the next operation is in flight.
  always_comb begin
    state_d  = state_q;
    aReg_d   = aReg_q;
    bReg_d   = bReg_q;
    resReg_d = resReg_q;
    borrow_d = borrow_q;
    count_d  = count_q;
    diff_d   = diff_q;
    bout_d   = bout_q;
    done_d   = 1'b0;
`ifdef SERIAL_SUB_OVF_EN
    ovfBit_d = ovfBit_q;
    ovf_d    = ovf_q;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          aReg_d   = A;
          bReg_d   = B;
          borrow_d = Bin;
          resReg_d = '0;
          count_d  = '0;
          state_d  = SHIFT;
        end
      end

      SHIFT: begin
        // The result enters from the MSB side, so after WIDTH shifts the
        // first (LSB) difference bit has reached bit 0.
        resReg_d = {dBit, resReg_q[WIDTH-1:1]};
        aReg_d   = aReg_q >> 1;
        bReg_d   = bReg_q >> 1;
        borrow_d = brNext;
        count_d  = count_q + CW'(1);
        if (count_q == LastBit) begin
          state_d = DONE;
`ifdef SERIAL_SUB_OVF_EN
          // On the MSB cycle the cell inputs are the operand sign bits.
          ovfBit_d = (aBit ^ bBit) & (aBit ^ dBit);
`endif
        end
      end

      DONE: begin
        diff_d  = resReg_q;
        bout_d  = borrow_q;
        done_d  = 1'b1;
`ifdef SERIAL_SUB_OVF_EN
        ovf_d   = ovfBit_q;
`endif
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers. The asynchronous reset aborts any
  // operation in progress and clears the visible outputs immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      aReg_q   <= '0;
      bReg_q   <= '0;
      resReg_q <= '0;
      borrow_q <= 1'b0;
      count_q  <= '0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovfBit_q <= 1'b0;
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      aReg_q   <= aReg_d;
      bReg_q   <= bReg_d;
      resReg_q <= resReg_d;
      borrow_q <= borrow_d;
      count_q  <= count_d;
      diff_q   <= diff_d;
      bout_q   <= bout_d;
      done_q   <= done_d;
`ifdef SERIAL_SUB_OVF_EN
      ovfBit_q <= ovfBit_d;
      ovf_q    <= ovf_d;
`endif
    end
  end

  // Output mapping.
  always_comb begin
    busy = (state_q == SHIFT);
    done = done_q;
    Diff = diff_q;
    Bout = bout_q;
`ifdef SERIAL_SUB_OVF_EN
    ovf  = ovf_q;
`endif
  end

endmodule

// File: tb/tb_serial_subtractor_4bits.sv
// -----------------------------------------------------------------------------
// tb_serial_subtractor_4bits
//
// Self-checking bench for serial_subtractor_4bits (WIDTH = 4). It uses a
// directed vector table, an exhaustive sweep, randomized operations with
// operand scrambling, and hand-written multi-cycle corner cases. It also
// checks the optional ovf output when SERIAL_SUB_OVF_EN is defined.
// -----------------------------------------------------------------------------
module tb_serial_subtractor_4bits;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] A, B;
  logic         Bin;
  logic         busy, done, Bout;
  logic [W-1:0] Diff;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
`endif

  int vectorsApplied = 0;
  int miscompares    = 0;

  serial_subtractor_4bits #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (A),
    .B     (B),
    .Bin   (Bin),
    .busy  (busy),
    .done  (done),
    .Diff  (Diff),
    .Bout  (Bout)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  // Free-running clock, 10 time-unit period.
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic [W-1:0] d;
    logic         bo;
    logic         ov;
  } vec_t;

  // Compares one value and records the outcome.
  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    vectorsApplied++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model: plain integer arithmetic on the operands.
  task automatic refSub(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic bin, output logic [W-1:0] d,
                        output logic bo, output logic ov);
    int r, sa, sb, sr;
    r  = int'(a) - int'(b) - int'(bin);
    d  = W'(r & ((1 << W) - 1));
    bo = (r < 0);
    sa = a[W-1] ? int'(a) - (1 << W) : int'(a);
    sb = b[W-1] ? int'(b) - (1 << W) : int'(b);
    sr = sa - sb - int'(bin);
    ov = (sr > (1 << (W-1)) - 1) || (sr < -(1 << (W-1)));
  endtask

  // Runs one operation. It returns the sampled results, the latency (in
  // edges) from the accepting edge, the number of busy cycles, an overlap
  // flag, and whether done fired again on the following cycle.
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic bin, input bit scramble,
                               output logic [W-1:0] d, output logic bo,
                               output logic ov, output int lat,
                               output int busyCnt, output bit overlap,
                               output bit secondDone);
    bit seen;
    @(negedge clk);
    A = a; B = b; Bin = bin; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (scramble) begin
      A = W'($urandom); B = W'($urandom); Bin = 1'($urandom);
    end
    lat = 0; busyCnt = 0; overlap = 1'b0; seen = 1'b0;
    d = 'x; bo = 1'bx; ov = 1'bx;
    while (!seen && lat < 4 * W + 8) begin
      @(negedge clk);
      if (busy) busyCnt++;
      if (busy && done) overlap = 1'b1;
      if (done) begin
        seen = 1'b1;
        d  = Diff;
        bo = Bout;
`ifdef SERIAL_SUB_OVF_EN
        ov = ovf;
`else
        ov = 1'b0;
`endif
      end else begin
        if (scramble && busy) begin
          start = 1'($urandom);
          A = W'($urandom); B = W'($urandom); Bin = 1'($urandom);
        end else begin
          start = 1'b0;
        end
        @(posedge clk);
        lat++;
      end
    end
    start = 1'b0;
    @(negedge clk);
    secondDone = done | busy;
  endtask

  // Runs an operation and compares every observable aspect against the model.
  task automatic runAndCheck(input string tag, input logic [W-1:0] a,
                             input logic [W-1:0] b, input logic bin,
                             input bit scramble, input bit fullCheck);
    logic [W-1:0] d, expD;
    logic         bo, ov, expBo, expOv;
    int           lat, busyCnt;
    bit           overlap, secondDone;
    refSub(a, b, bin, expD, expBo, expOv);
    applyStimulus(a, b, bin, scramble, d, bo, ov, lat, busyCnt, overlap,
                  secondDone);
    checkOutput({tag, " Diff"}, 32'(d), 32'(expD));
    checkOutput({tag, " Bout"}, 32'(bo), 32'(expBo));
`ifdef SERIAL_SUB_OVF_EN
    checkOutput({tag, " ovf"}, 32'(ov), 32'(expOv));
`endif
    if (fullCheck) begin
      checkOutput({tag, " latency"}, 32'(lat), 32'(W + 1));
      checkOutput({tag, " busyCycles"}, 32'(busyCnt), 32'(W));
      checkOutput({tag, " busyDoneOverlap"}, 32'(overlap), 32'd0);
      checkOutput({tag, " singlePulse"}, 32'(secondDone), 32'd0);
    end
  endtask

  vec_t vecs[7];

  initial begin
    logic [W-1:0] d0, d1;
    int           doneTimes[$];
    int           doneCnt;

    vecs[0] = '{a: 4'd9,  b: 4'd9,  bin: 1'b1, d: 4'hF, bo: 1'b1, ov: 1'b0};
    vecs[1] = '{a: 4'd9,  b: 4'd9,  bin: 1'b0, d: 4'h0, bo: 1'b0, ov: 1'b0};
    vecs[2] = '{a: 4'd12, b: 4'd5,  bin: 1'b0, d: 4'h7, bo: 1'b0, ov: 1'b1};
    vecs[3] = '{a: 4'd3,  b: 4'd10, bin: 1'b0, d: 4'h9, bo: 1'b1, ov: 1'b1};
    vecs[4] = '{a: 4'd6,  b: 4'd2,  bin: 1'b0, d: 4'h4, bo: 1'b0, ov: 1'b0};
    vecs[5] = '{a: 4'd7,  b: 4'd8,  bin: 1'b0, d: 4'hF, bo: 1'b1, ov: 1'b1};
    vecs[6] = '{a: 4'd5,  b: 4'd3,  bin: 1'b0, d: 4'h2, bo: 1'b0, ov: 1'b0};

    // Reset held with start asserted: nothing may start, outputs are zero.
    rst_n = 1'b0; start = 1'b1; A = 4'd9; B = 4'd3; Bin = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset done", 32'(done), 32'd0);
    checkOutput("reset Diff", 32'(Diff), 32'd0);
    checkOutput("reset Bout", 32'(Bout), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
    checkOutput("reset ovf", 32'(ovf), 32'd0);
`endif
    start = 1'b0;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("idle after reset busy", 32'(busy), 32'd0);

    // Directed vector table with hand-computed expectations.
    for (int i = 0; i < 7; i++) begin
      logic [W-1:0] d;
      logic         bo, ov;
      int           lat, busyCnt;
      bit           overlap, secondDone;
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].bin, 1'b0, d, bo, ov, lat,
                    busyCnt, overlap, secondDone);
      checkOutput($sformatf("vec%0d Diff", i), 32'(d), 32'(vecs[i].d));
      checkOutput($sformatf("vec%0d Bout", i), 32'(bo), 32'(vecs[i].bo));
`ifdef SERIAL_SUB_OVF_EN
      checkOutput($sformatf("vec%0d ovf", i), 32'(ov), 32'(vecs[i].ov));
`endif
      checkOutput($sformatf("vec%0d latency", i), 32'(lat), 32'(W + 1));
      checkOutput($sformatf("vec%0d busyCycles", i), 32'(busyCnt), 32'(W));
    end

    // Exhaustive sweep of A, B and Bin against the model.
    for (int i = 0; i < 512; i++) begin
      runAndCheck($sformatf("sweep a=%0d b=%0d bin=%0d", i[7:4], i[3:0], i[8]),
                  W'(i >> 4), W'(i), 1'(i >> 8), 1'b0, 1'b0);
    end

    // Random operations with start and operand changes during SHIFT.
    for (int i = 0; i < 150; i++) begin
      runAndCheck($sformatf("rand%0d", i), W'($urandom), W'($urandom),
                  1'($urandom), 1'b1, 1'b1);
    end

    // Start held high: back-to-back operations, one result per W+2 cycles.
    @(negedge clk);
    A = 4'd12; B = 4'd5; Bin = 1'b0; start = 1'b1;
    doneCnt = 0;
    for (int c = 0; c < 3 * (W + 2) + 2; c++) begin
      @(negedge clk);
      if (done) begin
        doneTimes.push_back(c);
        if (doneCnt == 0) d0 = Diff;
        if (doneCnt == 1) d1 = Diff;
        doneCnt++;
      end
    end
    start = 1'b0;
    checkOutput("held start done count", 32'(doneCnt >= 2), 32'd1);
    if (doneTimes.size() >= 2) begin
      checkOutput("held start spacing", 32'(doneTimes[1] - doneTimes[0]),
                  32'(W + 2));
      checkOutput("held start Diff0", 32'(d0), 32'd7);
      checkOutput("held start Diff1", 32'(d1), 32'd7);
    end
    repeat (2 * (W + 2)) @(negedge clk);

    // Reset at the 2nd SHIFT cycle: asynchronous clear, no done pulse.
    checkOutput("pre-abort Diff", 32'(Diff), 32'd7);
    @(negedge clk);
    A = 4'd15; B = 4'd1; Bin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("abort busy", 32'(busy), 32'd0);
    checkOutput("abort done", 32'(done), 32'd0);
    checkOutput("abort Diff", 32'(Diff), 32'd0);
    checkOutput("abort Bout", 32'(Bout), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    doneCnt = 0;
    for (int c = 0; c < 2 * W + 4; c++) begin
      @(negedge clk);
      if (done || busy) doneCnt++;
    end
    checkOutput("abort no activity", 32'(doneCnt), 32'd0);
    runAndCheck("after abort 6-2", 4'd6, 4'd2, 1'b0, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied,
             miscompares);
    $finish;
  end

  // Global watchdog so the bench can never hang.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    miscompares++;
    $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied,
             miscompares);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
